hazard_forward_unit: RTL

Parametrised hazard-detection and forwarding controller for the pipelined MIPS core. It generalises the fixed five-stage pipeline to a configurable number of memory stages. It keeps its own scoreboard of in-flight writers, and from that it drives load-use stalls, branch flushes and registered EX-stage forwarding selects. It sits beside the ID stage: it consumes decoded source and destination info, and its outputs steer the PC/IF_ID hold, the pipeline-register bubbles and the ALU operand muxes.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/inflight_tracker.sv | 40 ++++
 rtl/hazard_forward_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller and its
// in-flight writer tracker.
package hazard_pkg;

    // Widest register address the tracker can hold; REG_AW must not exceed it.
    localparam int TRK_DST_W   = 8;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memtoreg;
        logic [TRK_DST_W-1:0] dst;
    } trk_entry_t;

    // True when a producer sitting at stage s (0=EX, m+1=WB) can feed EX.
    function automatic logic load_ready(input int s, input int m, input logic memtoreg);
        return (s >= m + 1) || (!memtoreg && (s >= 1));
    endfunction

endpackage

// File: rtl/inflight_tracker.sv
// Shift register of in-flight writers, one entry per stage from EX to WB,
// with bubble insertion at EX entry and squash of the instruction leaving EX.
module inflight_tracker
    import hazard_pkg::*;
#(
    parameter int MEM_STAGES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       squash_ex,
    input  trk_entry_t id_entry,
    output trk_entry_t entry_q [MEM_STAGES+2]
);
    localparam int DEPTH = MEM_STAGES + 2;

    trk_entry_t entry_d [DEPTH];

    always_comb begin
        entry_d[0] = advance ? id_entry : '0;
        entry_d[1] = entry_q[0];
        if (squash_ex) begin
            entry_d[1].valid = 1'b0;
        end
        for (int s = 2; s < DEPTH; s++) begin
            entry_d[s] = entry_q[s-1];
        end
    end

    // NOTE: these entries are individual flops rather than a RAM, so every one
    // is cleared on reset; state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '{default: '0};
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and EX forwarding controller for the pipelined MIPS core
// with a configurable number of memory stages between EX and WB.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int MEM_STAGES = 1,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(MEM_STAGES + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              mem_branch_taken,
    output logic              stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam int DEPTH = MEM_STAGES + 2;

    trk_entry_t       trk_q [DEPTH];
    trk_entry_t       id_entry;
    logic             advance;
    logic             a_hit, b_hit, a_block, b_block;
    logic [SEL_W-1:0] a_sel, b_sel;
    logic [SEL_W-1:0] fwd_a_sel_d, fwd_a_sel_q, fwd_b_sel_d, fwd_b_sel_q;
    logic [CNT_W-1:0] stall_count_d, stall_count_q, flush_count_d, flush_count_q;

    inflight_tracker #(.MEM_STAGES(MEM_STAGES)) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .squash_ex(mem_branch_taken),
        .id_entry (id_entry),
        .entry_q  (trk_q)
    );

    // WB producers reach ID through the write-through register file, so the
    // search covers EX..MEMn only; scanning oldest first lets the youngest win.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        a_hit   = 1'b0;
        b_hit   = 1'b0;
        a_block = 1'b0;
        b_block = 1'b0;
        a_sel   = SEL_W'(SEL_REGFILE);
        b_sel   = SEL_W'(SEL_REGFILE);
        for (int s = MEM_STAGES; s >= 0; s--) begin
            if (trk_q[s].valid && trk_q[s].regwrite && (trk_q[s].dst != '0)) begin
                if (trk_q[s].dst == TRK_DST_W'(id_rs)) begin
                    a_hit   = 1'b1;
                    a_sel   = SEL_W'(s + 1);
                    a_block = !load_ready(s + 1, MEM_STAGES, trk_q[s].memtoreg);
                end
                if (trk_q[s].dst == TRK_DST_W'(id_rt)) begin
                    b_hit   = 1'b1;
                    b_sel   = SEL_W'(s + 1);
                    b_block = !load_ready(s + 1, MEM_STAGES, trk_q[s].memtoreg);
                end
            end
        end
    end

    // A taken branch squashes the ID instruction, so it overrides any stall.
    assign stall        = id_valid && !mem_branch_taken &&
                          ((id_uses_rs && a_block) || (id_uses_rt && b_block));
    assign flush_if_id  = mem_branch_taken;
    assign flush_id_ex  = mem_branch_taken;
    assign flush_ex_mem = mem_branch_taken;

    always_comb begin
        advance  = !stall && !mem_branch_taken;
        id_entry = '{valid:    id_valid,
                     regwrite: id_regwrite,
                     memtoreg: id_memtoreg,
                     dst:      TRK_DST_W'(id_dst)};

        fwd_a_sel_d = (advance && id_valid && id_uses_rs && a_hit) ? a_sel : SEL_W'(SEL_REGFILE);
        fwd_b_sel_d = (advance && id_valid && id_uses_rt && b_hit) ? b_sel : SEL_W'(SEL_REGFILE);

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        flush_count_d = flush_count_q;
        if (mem_branch_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_a_sel_q   <= '0;
            fwd_b_sel_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fwd_a_sel_q   <= fwd_a_sel_d;
            fwd_b_sel_q   <= fwd_b_sel_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fwd_a_sel   = fwd_a_sel_q;
    assign fwd_b_sel   = fwd_b_sel_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
